tdc_pulse_pair_gen: RTL and testbench

- Digital stimulus source for the vernier TDC. Emits a start pulse and a stop pulse separated by a programmable number of clk cycles.
- Drives the start and stop inputs of the TDC front-end for calibration and linearity sweeps.
- Supports bursts of repeated pairs with a programmable idle gap between pairs.
- Sits beside the analog core. Its outputs route to ua pins or directly to the delay-line inputs.

---
 rtl/tdc_pkg.sv | 17 +
 rtl/tdc_pulse_window.sv | 35 +++
 rtl/tdc_pulse_pair_gen.sv | 140 ++++++++++++++
 tb/tb_tdc_pulse_pair_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and width constants for the TDC pulse-pair stimulus generator.
package tdc_pkg;

    localparam int unsigned DLY_W = 8;
    localparam int unsigned PW_W  = 4;
    localparam int unsigned CNT_W = 8;

    // Smallest pulse width that is actually emitted; a programmed width of 0 maps to this.
    localparam int unsigned W_MIN = 1;

    typedef enum logic [1:0] {
        IDLE,
        PAIR,
        GAP
    } state_e;

endpackage

// File: rtl/tdc_pulse_window.sv
// Registered start/stop window comparators for one pulse pair at offset t.
module tdc_pulse_window #(
    parameter int unsigned DLY_W = 8,
    parameter int unsigned PW_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DLY_W:0]   t,
    input  logic [DLY_W-1:0] d,
    input  logic [PW_W-1:0]  w,
    output logic             start_o,
    output logic             stop_o
);

    logic [DLY_W:0] d_ext;
    logic [DLY_W:0] w_ext;
    logic [DLY_W:0] stop_end;

    // Extra bit keeps D+W from overflowing at the maximum settings.
    assign d_ext    = {1'b0, d};
    assign w_ext    = {{(DLY_W + 1 - PW_W){1'b0}}, w};
    assign stop_end = d_ext + w_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_o <= 1'b0;
            stop_o  <= 1'b0;
        end else begin
            start_o <= en && (t < w_ext);
            stop_o  <= en && (t >= d_ext) && (t < stop_end);
        end
    end

endmodule

// File: rtl/tdc_pulse_pair_gen.sv
// Burst sequencer emitting start/stop pulse pairs with programmable spacing, width and gap.
module tdc_pulse_pair_gen #(
    parameter int unsigned DLY_W = 8,
    parameter int unsigned PW_W  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             abort,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [PW_W-1:0]  cfg_width,
    input  logic [DLY_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_repeat,
    output logic             start_o,
    output logic             stop_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pair_cnt
);

    import tdc_pkg::*;

    state_e             state_q, state_n;
    logic [DLY_W:0]     t_q, t_n;
    logic [DLY_W-1:0]   gap_q, gap_n;
    logic [CNT_W-1:0]   rem_q, rem_n;
    logic [CNT_W-1:0]   cnt_n;
    logic [DLY_W-1:0]   d_q, d_n;
    logic [PW_W-1:0]    w_q, w_n;
    logic [DLY_W-1:0]   g_q, g_n;
    logic               busy_n;
    logic               done_n;
    logic [DLY_W:0]     last_t;

    assign last_t = {1'b0, d_q} + {{(DLY_W + 1 - PW_W){1'b0}}, w_q} - (DLY_W + 1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            t_q      <= '0;
            gap_q    <= '0;
            rem_q    <= '0;
            pair_cnt <= '0;
            d_q      <= '0;
            w_q      <= '0;
            g_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_n;
            t_q      <= t_n;
            gap_q    <= gap_n;
            rem_q    <= rem_n;
            pair_cnt <= cnt_n;
            d_q      <= d_n;
            w_q      <= w_n;
            g_q      <= g_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        t_n     = t_q;
        gap_n   = gap_q;
        rem_n   = rem_q;
        cnt_n   = pair_cnt;
        d_n     = d_q;
        w_n     = w_q;
        g_n     = g_q;
        busy_n  = busy;
        done_n  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig && !abort) begin
                    d_n     = cfg_delay;
                    w_n     = (cfg_width == '0) ? PW_W'(W_MIN) : cfg_width;
                    g_n     = cfg_gap;
                    rem_n   = cfg_repeat;
                    cnt_n   = '0;
                    t_n     = '0;
                    busy_n  = 1'b1;
                    state_n = PAIR;
                end
            end
            PAIR: begin
                if (abort) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (t_q == last_t) begin
                    cnt_n = pair_cnt + 1'b1;
                    t_n   = '0;
                    if (rem_q == '0) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        rem_n = rem_q - 1'b1;
                        if (g_q != '0) begin
                            gap_n   = g_q;
                            state_n = GAP;
                        end
                    end
                end else begin
                    t_n = t_q + 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (gap_q == DLY_W'(1)) begin
                    t_n     = '0;
                    state_n = PAIR;
                end else begin
                    gap_n = gap_q - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Window sees next-state values so the registered pulses line up with busy.
    tdc_pulse_window #(
        .DLY_W (DLY_W),
        .PW_W  (PW_W)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .en      (state_n == PAIR),
        .t       (t_n),
        .d       (d_n),
        .w       (w_n),
        .start_o (start_o),
        .stop_o  (stop_o)
    );

endmodule

// File: tb/tb_tdc_pulse_pair_gen.sv
// Directed self-checking bench for tdc_pulse_pair_gen.
module tb_tdc_pulse_pair_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_delay = '0;
    logic [3:0] cfg_width = '0;
    logic [7:0] cfg_gap = '0;
    logic [7:0] cfg_repeat = '0;
    logic       start_o, stop_o, busy, done;
    logic [7:0] pair_cnt;

    int tests = 0;
    int fails = 0;
    logic [63:0] st, sp, bz, dn;

    always #5 clk = ~clk;

    tdc_pulse_pair_gen #(
        .DLY_W (8),
        .PW_W  (4),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trig       (trig),
        .abort      (abort),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_gap    (cfg_gap),
        .cfg_repeat (cfg_repeat),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .busy       (busy),
        .done       (done),
        .pair_cnt   (pair_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bit_at(input int n);
        logic [63:0] m = '0;
        m[n] = 1'b1;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a burst; afterwards the bench sits in cycle 1. Scrambled cfg must not matter.
    task automatic go(input int d, input int w, input int g, input int r, input bit scramble);
        cfg_delay  = 8'(d);
        cfg_width  = 4'(w);
        cfg_gap    = 8'(g);
        cfg_repeat = 8'(r);
        trig = 1'b1;
        step();
        trig = 1'b0;
        if (scramble) begin
            cfg_delay  = 8'($urandom);
            cfg_width  = 4'($urandom);
            cfg_gap    = 8'($urandom);
            cfg_repeat = 8'($urandom);
        end
    endtask

    task automatic capture(input int n, input logic [63:0] tmask, input int ab_cyc);
        st = '0; sp = '0; bz = '0; dn = '0;
        for (int c = 1; c <= n; c++) begin
            st[c] = start_o;
            sp[c] = stop_o;
            bz[c] = busy;
            dn[c] = done;
            trig  = tmask[c];
            abort = (c == ab_cyc);
            step();
        end
        trig  = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int dcyc;

        repeat (3) step();
        check("rst_start", 64'(start_o), 64'd0);
        check("rst_stop",  64'(stop_o),  64'd0);
        check("rst_busy",  64'(busy),    64'd0);
        check("rst_done",  64'(done),    64'd0);
        check("rst_cnt",   64'(pair_cnt), 64'd0);
        rst = 1'b0;
        repeat (2) step();

        // basic pair D=5 W=2 R=1
        go(5, 2, 0, 0, 1'b1);
        capture(12, '0, -1);
        check("basic_start", st, rng(1, 2));
        check("basic_stop",  sp, rng(6, 7));
        check("basic_busy",  bz, rng(1, 7));
        check("basic_done",  dn, bit_at(8));
        check("basic_cnt",   64'(pair_cnt), 64'd1);

        // zero delay, zero width
        go(0, 0, 0, 0, 1'b1);
        capture(6, '0, -1);
        check("zero_start", st, bit_at(1));
        check("zero_stop",  sp, bit_at(1));
        check("zero_done",  dn, bit_at(2));

        // overlapping pulses
        go(1, 4, 0, 0, 1'b1);
        capture(10, '0, -1);
        check("ovl_start", st, rng(1, 4));
        check("ovl_stop",  sp, rng(2, 5));
        check("ovl_done",  dn, bit_at(6));

        // burst of 3 with gap 2
        go(3, 1, 2, 2, 1'b1);
        capture(20, '0, -1);
        check("burst_start", st, bit_at(1) | bit_at(7) | bit_at(13));
        check("burst_stop",  sp, bit_at(4) | bit_at(10) | bit_at(16));
        check("burst_busy",  bz, rng(1, 16));
        check("burst_done",  dn, bit_at(17));
        check("burst_cnt",   64'(pair_cnt), 64'd3);

        // burst of 3 without gap
        go(3, 1, 0, 2, 1'b1);
        capture(16, '0, -1);
        check("nogap_start", st, bit_at(1) | bit_at(5) | bit_at(9));
        check("nogap_stop",  sp, bit_at(4) | bit_at(8) | bit_at(12));
        check("nogap_done",  dn, bit_at(13));
        check("nogap_cnt",   64'(pair_cnt), 64'd3);

        // ignored trig during burst, abort in cycle 8
        go(3, 1, 2, 2, 1'b1);
        capture(20, bit_at(3) | bit_at(6), 8);
        check("abort_start", st, bit_at(1) | bit_at(7));
        check("abort_stop",  sp, bit_at(4));
        check("abort_busy",  bz, rng(1, 8));
        check("abort_done",  dn, 64'd0);
        check("abort_cnt",   64'(pair_cnt), 64'd1);

        // abort together with trig in IDLE
        cfg_delay = 8'd2; cfg_width = 4'd1; cfg_repeat = '0; cfg_gap = '0;
        trig = 1'b1; abort = 1'b1;
        step();
        trig = 1'b0; abort = 1'b0;
        check("abtrig_start", 64'(start_o), 64'd0);
        check("abtrig_busy",  64'(busy),    64'd0);
        step();
        check("abtrig_start2", 64'(start_o), 64'd0);

        // trig in the done cycle starts a new burst
        go(0, 1, 0, 0, 1'b0);
        capture(8, bit_at(2), -1);
        check("redo_start", st, bit_at(1) | bit_at(3));
        check("redo_done",  dn, bit_at(2) | bit_at(4));
        check("redo_cnt",   64'(pair_cnt), 64'd1);

        // async reset mid-pair
        go(5, 4, 0, 0, 1'b1);
        step();
        check("arst_pre_start", 64'(start_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_start", 64'(start_o), 64'd0);
        check("arst_busy",  64'(busy),    64'd0);
        check("arst_cnt",   64'(pair_cnt), 64'd0);
        #2 rst = 1'b0;
        step();
        check("arst_idle", 64'(busy), 64'd0);
        go(5, 2, 0, 0, 1'b1);
        capture(12, '0, -1);
        check("arst_again_start", st, rng(1, 2));
        check("arst_again_stop",  sp, rng(6, 7));
        check("arst_again_done",  dn, bit_at(8));

        // 256 pairs: pair_cnt wraps to 0
        go(0, 0, 0, 255, 1'b1);
        dcyc = -1;
        for (int c = 1; c <= 400; c++) begin
            if (done) begin
                dcyc = c;
                break;
            end
            step();
        end
        check("wrap_done_cycle", 64'(dcyc), 64'd257);
        check("wrap_cnt",        64'(pair_cnt), 64'd0);
        check("wrap_busy",       64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
